// File: rtl/fifo_stream_pkg.sv
// Shared helpers for the FIFO stream reader: width of the buffer occupancy count.
package fifo_stream_pkg;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Prefetch buffer: circular storage with head/tail/count and a push/pop interface.
module stream_skid_buf import fifo_stream_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                clr,
  input  logic                                push,
  input  logic [DATA_WIDTH-1:0]               push_data,
  input  logic                                pop,
  output logic                                out_valid,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [count_width(BUF_DEPTH)-1:0]   count
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = count_width(BUF_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [AW-1:0]         head_q, head_d;
  logic [AW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  valid_q, valid_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (pop) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    // Power-of-two depth lets the pointers wrap by natural overflow.
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drives the read side of a registered-output FIFO and re-presents its words as a
// full-throughput valid/ready stream. Note: m_ready reaches fifo_rd_en combinationally.
module fifo_stream_reader import fifo_stream_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                fifo_empty,
  output logic                                fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]               fifo_data_out,
  input  logic                                flush,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [DATA_WIDTH-1:0]               m_data,
  output logic [count_width(BUF_DEPTH)-1:0]   buf_count
);

  localparam int CW = count_width(BUF_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

  logic          inflight_q, inflight_d;
  logic          pop;
  logic          room;
  logic [CW-1:0] count;

  assign pop  = m_valid & m_ready;
  // Reserve a slot for the word already on its way out of the FIFO.
  assign room = ({1'b0, count} + {{CW{1'b0}}, inflight_q}) < DEPTH_C;
  assign fifo_rd_en = n_rst & ~fifo_empty & ~flush & (room | pop);

  always_comb begin
    inflight_d = 1'b0;
    if (flush) begin
      inflight_d = 1'b0;
    end else begin
      inflight_d = fifo_rd_en & ~fifo_empty;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  // A word landing during flush belongs to the discarded stream, so clr overrides push.
  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr       (flush),
    .push      (inflight_q),
    .push_data (fifo_data_out),
    .pop       (pop),
    .out_valid (m_valid),
    .out_data  (m_data),
    .count     (count)
  );

  assign buf_count = count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a FIFO model and an in-order scoreboard.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int BD = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data_out;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] buf_count;

  logic [DW-1:0] fifo_mdl[$];
  logic [DW-1:0] exp_q[$];
  int            n_chk  = 0;
  int            n_pass = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .flush         (flush),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .buf_count     (buf_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // FIFO model: registered read data, valid only the cycle after acceptance.
  always @(posedge clk) begin
    if (n_rst && fifo_rd_en && !fifo_empty) begin
      fifo_data_out <= fifo_mdl.pop_front();
      fifo_empty    <= (fifo_mdl.size() == 0);
    end
  end

  // Monitor: in-order scoreboard, stall stability and per-cycle invariants.
  always @(negedge clk) begin
    if (!n_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, m_valid}, 32'd1);
        chk("hold_data", {24'd0, m_data}, {24'd0, prev_data});
      end
      chk("rd_en_on_empty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
      chk("buf_count_max", {31'd0, (buf_count <= CW'(BD))}, 32'd1);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_word: got %0h expected none", m_data);
        end else begin
          chk("data_order", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_stall = m_valid && !m_ready && !flush;
      prev_data  = m_data;
    end
  end

  task automatic load_seq(input logic [DW-1:0] base, input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = base + DW'(i);
      fifo_mdl.push_back(w);
      exp_q.push_back(w);
    end
    fifo_empty <= 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      seen = m_valid;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_drain(input string name, input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    chk({name, "_idle"}, {31'd0, m_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rd;
    n_rst = 1'b0; flush = 1'b0; m_ready = 1'b1;
    fifo_empty = 1'b1; fifo_data_out = '0;
    #2;
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_count", {30'd0, buf_count}, 32'd0);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    load_seq(8'hA1, 3);
    #1;
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);

    // Test 1: release reset with three words waiting.
    @(posedge clk); #1 n_rst = 1'b1;
    @(negedge clk);
    chk("t1_rd_en_c0", {31'd0, fifo_rd_en}, 32'd1);
    chk("t1_valid_c0", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    chk("t1_valid_c1", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    chk("t1_valid_c2", {31'd0, m_valid}, 32'd1);
    chk("t1_data_c2", {24'd0, m_data}, 32'hA1);
    @(negedge clk);
    chk("t1_data_c3", {24'd0, m_data}, 32'hA2);
    @(negedge clk);
    chk("t1_data_c4", {24'd0, m_data}, 32'hA3);
    @(negedge clk);
    chk("t1_valid_c5", {31'd0, m_valid}, 32'd0);
    chk("t1_count_c5", {30'd0, buf_count}, 32'd0);

    // Test 2: 16 words at full rate.
    @(posedge clk); #1 load_seq(8'h10, 16);
    wait_valid("t2_first", 10);
    for (int i = 0; i < 16; i++) begin
      chk("t2_no_gap", {31'd0, m_valid}, 32'd1);
      @(negedge clk);
    end
    chk("t2_end", {31'd0, m_valid}, 32'd0);

    // Test 3: consumer stalled for 10 cycles.
    @(posedge clk); #1 m_ready = 1'b0; load_seq(8'h40, 8);
    rd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en && !fifo_empty) rd++;
    end
    chk("t3_reads", rd, 32'd2);
    chk("t3_count", {30'd0, buf_count}, 32'd2);
    chk("t3_data", {24'd0, m_data}, 32'h40);
    @(posedge clk); #1 m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3_no_gap", {31'd0, m_valid}, 32'd1);
    end
    @(negedge clk);
    chk("t3_end", {31'd0, m_valid}, 32'd0);

    // Test 4: m_ready toggling over 32 words.
    @(posedge clk); #1 load_seq(8'h60, 32);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1 m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    wait_drain("t4_drain", 60);

    // Test 5: flush with one word buffered and one in flight.
    @(posedge clk); #1 m_ready = 1'b0; load_seq(8'h80, 6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_count_pre", {30'd0, buf_count}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    chk("t5_rd_en_flush", {31'd0, fifo_rd_en}, 32'd0);
    @(posedge clk); #1 flush = 1'b0;
    chk("t5_valid_post", {31'd0, m_valid}, 32'd0);
    chk("t5_count_post", {30'd0, buf_count}, 32'd0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    m_ready = 1'b1;
    wait_valid("t5_first", 10);
    chk("t5_next_word", {24'd0, m_data}, 32'h82);
    wait_drain("t5_drain", 20);

    // Test 6: asynchronous reset mid-stream.
    @(posedge clk); #1 load_seq(8'hC0, 8);
    repeat (4) @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    chk("t6_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("t6_count", {30'd0, buf_count}, 32'd0);
    fifo_mdl.delete();
    exp_q.delete();
    fifo_empty <= 1'b1;
    @(posedge clk); #1 n_rst = 1'b1; load_seq(8'hD0, 3);
    wait_drain("t6_recover", 20);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
